// File: rtl/counter_pkg.sv
// Shared constants for the up/down counter family.
// Mode selects wrap-around or one-shot behaviour; direction encodes up_dn.
package counter_pkg;

    localparam int MODE_WRAP    = 0;
    localparam int MODE_ONESHOT = 1;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage : counter_pkg

// File: rtl/counter_updown_sync_cnt_next.sv
// Next-value and terminal detect for a modulo-MODULUS up/down counter.
// Latency: purely combinational.
// Backpressure: none; always produces a result for the presented count.
module cnt_next
    import counter_pkg::*;
#(
    parameter int              WIDTH   = 4,
    parameter longint unsigned MODULUS = 16
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up_dn,
    output logic [WIDTH-1:0] nxt,
    output logic             at_term
);

    // MODULUS-1 always fits in WIDTH bits, even when MODULUS == 2^WIDTH.
    localparam logic [WIDTH-1:0] TERM = WIDTH'(MODULUS - 64'd1);

    always_comb begin
        nxt     = count;
        at_term = 1'b0;
        if (up_dn == DIR_UP) begin
            at_term = (count == TERM);
            nxt     = at_term ? '0 : count + WIDTH'(1);
        end else begin
            at_term = (count == '0);
            nxt     = at_term ? TERM : count - WIDTH'(1);
        end
    end

endmodule : cnt_next

// File: rtl/counter_updown_sync.sv
// Synchronous modulo up/down counter with load, wrap pulse and one-shot done.
// Latency: one clk edge from inputs to count/wrap/done; tc is combinational.
// Backpressure: none; every edge applies rst > load > en, otherwise holds.
module counter_updown_sync
    import counter_pkg::*;
#(
    parameter int              WIDTH   = 4,
    parameter longint unsigned MODULUS = 16,
    parameter int              MODE    = MODE_WRAP,
    parameter longint unsigned INIT    = MODULUS - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             done
);

    localparam logic [WIDTH-1:0] TERM   = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] INIT_C = (INIT >= MODULUS) ? TERM : WIDTH'(INIT);

    logic [WIDTH-1:0] count_q;
    logic             wrap_q;
    logic             done_q;
    logic [WIDTH-1:0] nxt;
    logic             at_term;
    logic [WIDTH-1:0] load_clamped;
    logic             reach_term;

    cnt_next #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_cnt_next (
        .count   (count_q),
        .up_dn   (up_dn),
        .nxt     (nxt),
        .at_term (at_term)
    );

    // Compare in 64 bits so MODULUS == 2^32 never truncates.
    assign load_clamped = (64'(load_val) >= MODULUS) ? TERM : load_val;

    // One-shot: done rises on the step that lands on the terminal value.
    assign reach_term = (up_dn == DIR_UP) ? (nxt == TERM) : (nxt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= INIT_C;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (load) begin
            count_q <= load_clamped;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (en) begin
            if (MODE == MODE_ONESHOT) begin
                wrap_q <= 1'b0;
                if (!done_q) begin
                    if (at_term) begin
                        done_q <= 1'b1;
                    end else begin
                        count_q <= nxt;
                        done_q  <= reach_term;
                    end
                end
            end else begin
                count_q <= nxt;
                wrap_q  <= at_term;
                done_q  <= 1'b0;
            end
        end else begin
            wrap_q <= 1'b0;
        end
    end

    assign count = count_q;
    assign tc    = at_term;
    assign wrap  = wrap_q;
    assign done  = done_q;

endmodule : counter_updown_sync

// File: tb/tb_counter_updown_sync.sv
// Directed bench: three counters (wrap M10, one-shot M10, wrap M16) on one clock.
module tb_counter_updown_sync;

    logic       clk;
    logic       rst      [3];
    logic       en       [3];
    logic       up_dn    [3];
    logic       load     [3];
    logic [3:0] load_val [3];
    logic [3:0] count    [3];
    logic       tc       [3];
    logic       wrap     [3];
    logic       done     [3];

    int vectors;
    int miscompares;

    counter_updown_sync #(.WIDTH(4), .MODULUS(10), .MODE(0)) d0 (
        .clk(clk), .rst(rst[0]), .en(en[0]), .up_dn(up_dn[0]), .load(load[0]),
        .load_val(load_val[0]), .count(count[0]), .tc(tc[0]), .wrap(wrap[0]), .done(done[0])
    );

    counter_updown_sync #(.WIDTH(4), .MODULUS(10), .MODE(1)) d1 (
        .clk(clk), .rst(rst[1]), .en(en[1]), .up_dn(up_dn[1]), .load(load[1]),
        .load_val(load_val[1]), .count(count[1]), .tc(tc[1]), .wrap(wrap[1]), .done(done[1])
    );

    counter_updown_sync #(.WIDTH(4), .MODULUS(16), .MODE(0)) d2 (
        .clk(clk), .rst(rst[2]), .en(en[2]), .up_dn(up_dn[2]), .load(load[2]),
        .load_val(load_val[2]), .count(count[2]), .tc(tc[2]), .wrap(wrap[2]), .done(done[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_cnt;
        int prev;
        vectors     = 0;
        miscompares = 0;
        for (int k = 0; k < 3; k++) begin
            rst[k]      = 1'b1;
            en[k]       = 1'b0;
            up_dn[k]    = 1'b0;
            load[k]     = 1'b0;
            load_val[k] = 4'd0;
        end
        up_dn[2] = 1'b1;
        step();
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;

        // Reset state
        chk("d0_rst_count", count[0], 9);
        chk("d0_rst_wrap",  wrap[0],  0);
        chk("d0_rst_done",  done[0],  0);
        chk("d0_rst_tc_dn", tc[0],    0);
        chk("d1_rst_count", count[1], 9);
        chk("d1_rst_done",  done[1],  0);
        chk("d2_rst_count", count[2], 15);
        chk("d2_rst_tc_up", tc[2],    1);

        // Down-count through the 0 -> 9 wrap
        en[0] = 1'b1; up_dn[0] = 1'b0;
        exp_cnt = 9;
        for (int i = 0; i < 11; i++) begin
            prev    = exp_cnt;
            exp_cnt = (prev == 0) ? 9 : prev - 1;
            step();
            chk($sformatf("d0_dn_count_%0d", i), count[0], exp_cnt);
            chk($sformatf("d0_dn_wrap_%0d", i),  wrap[0],  (prev == 0) ? 1 : 0);
        end

        // Up-count 8 -> 9 -> 0 -> 1, tc following up_dn combinationally
        up_dn[0] = 1'b1;
        step();
        chk("d0_up_count9", count[0], 9);
        chk("d0_up_tc9",    tc[0],    1);
        up_dn[0] = 1'b0; #1;
        chk("d0_tc_dir_dn", tc[0],    0);
        up_dn[0] = 1'b1; #1;
        chk("d0_tc_dir_up", tc[0],    1);
        step();
        chk("d0_up_count0", count[0], 0);
        chk("d0_up_wrap0",  wrap[0],  1);
        step();
        chk("d0_up_count1", count[0], 1);
        chk("d0_up_wrap1",  wrap[0],  0);

        // Load clamp, and load beating an enabled wrap step
        load[0] = 1'b1; load_val[0] = 4'd13;
        step();
        chk("d0_ld13_count", count[0], 9);
        chk("d0_ld13_wrap",  wrap[0],  0);
        load_val[0] = 4'd4;
        step();
        chk("d0_ld4_count", count[0], 4);
        chk("d0_ld4_wrap",  wrap[0],  0);

        // Reset overrides simultaneous load and enable
        load_val[0] = 4'd5;
        step();
        chk("d0_ld5_count", count[0], 5);
        rst[0] = 1'b1; load_val[0] = 4'd2;
        step();
        chk("d0_rstov_count", count[0], 9);
        chk("d0_rstov_wrap",  wrap[0],  0);
        chk("d0_rstov_done",  done[0],  0);
        rst[0] = 1'b0; load[0] = 1'b0; en[0] = 1'b0;

        // One-shot down from 2, freeze at 0, release on load
        load[1] = 1'b1; load_val[1] = 4'd2;
        step();
        chk("d1_ld2_count", count[1], 2);
        load[1] = 1'b0; en[1] = 1'b1;
        step();
        chk("d1_count1", count[1], 1);
        chk("d1_done1",  done[1],  0);
        step();
        chk("d1_count0", count[1], 0);
        chk("d1_done0",  done[1],  1);
        chk("d1_wrap0",  wrap[1],  0);
        for (int i = 0; i < 5; i++) begin
            up_dn[1] = (i % 2 == 1);
            step();
            chk($sformatf("d1_frz_count_%0d", i), count[1], 0);
            chk($sformatf("d1_frz_wrap_%0d", i),  wrap[1],  0);
            chk($sformatf("d1_frz_done_%0d", i),  done[1],  1);
        end
        load[1] = 1'b1; load_val[1] = 4'd7;
        step();
        chk("d1_ld7_count", count[1], 7);
        chk("d1_ld7_done",  done[1],  0);
        load[1] = 1'b0; en[1] = 1'b0;

        // Full-range modulus: 15 -> 0 -> 1
        en[2] = 1'b1;
        step();
        chk("d2_count0", count[2], 0);
        chk("d2_wrap0",  wrap[2],  1);
        chk("d2_tc0",    tc[2],    0);
        step();
        chk("d2_count1", count[2], 1);
        chk("d2_wrap1",  wrap[2],  0);
        en[2] = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_counter_updown_sync

// File: doc/counter_updown_sync.md
COUNTER_UPDOWN_SYNC -- requirements
Module: counter_updown_sync

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: counter bit width, legal range 1..32.
REQ-002 The block SHALL have parameter MODULUS, default 16: count range 0..MODULUS-1, legal range 2..2^WIDTH.
REQ-003 The block SHALL have parameter MODE, default 0: 0 = wrap-around, 1 = one-shot (stop at terminal).
REQ-004 The block SHALL have parameter INIT, default MODULUS-1: reset value of count.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port en, input, 1 bit: count enable.
REQ-008 The block SHALL have port up_dn, input, 1 bit: direction; 1 = up, 0 = down.
REQ-009 The block SHALL have port load, input, 1 bit: parallel load strobe.
REQ-010 The block SHALL have port load_val, input, WIDTH bits: value captured on load.
REQ-011 The block SHALL have port count, output, WIDTH bits: registered counter value.
REQ-012 The block SHALL have port tc, output, 1 bit: combinational terminal count, high when count is at the terminal value for the current up_dn (up: MODULUS-1; down: 0).
REQ-013 The block SHALL have port wrap, output, 1 bit: registered single-cycle pulse, high the cycle after count wraps.
REQ-014 The block SHALL have port done, output, 1 bit: registered, sticky in MODE 1 when the terminal value is reached; constant 0 in MODE 0.

Function
REQ-015 The per-edge priority SHALL be rst > load > en; with none active, count SHALL hold.
REQ-016 On load, count SHALL take load_val; if load_val >= MODULUS, count SHALL take MODULUS-1.
REQ-017 On load, done SHALL clear and wrap SHALL be 0 the next cycle.
REQ-018 With en=1 and up_dn=1, count SHALL increment by 1; at MODULUS-1 it SHALL become 0 (MODE 0).
REQ-019 With en=1 and up_dn=0, count SHALL decrement by 1; at 0 it SHALL become MODULUS-1 (MODE 0).
REQ-020 Latency SHALL be one edge: the value computed from inputs at edge N SHALL appear on count after edge N.
REQ-021 wrap SHALL be 1 for exactly the one cycle following an enabled terminal-to-wrap transition, and 0 otherwise.
REQ-022 In MODE 1, an enabled step that would wrap SHALL instead hold count at the terminal value, set done, and leave wrap at 0.
REQ-023 In MODE 1, count SHALL remain frozen while done=1, regardless of en or up_dn, until load or rst.
REQ-024 When up_dn changes while en=1, the new direction SHALL apply on that same edge; tc SHALL follow up_dn combinationally.
REQ-025 If load and en are both high, load SHALL win and no step or wrap SHALL occur.
REQ-026 Arithmetic SHALL be modulo MODULUS with no intermediate overflow for any WIDTH, including MODULUS = 2^WIDTH.

Reset
REQ-027 On rst=1 at a clk edge: count = INIT (clamped to MODULUS-1), wrap = 0, done = 0.
REQ-028 rst asserted mid-count or mid-load SHALL override all other inputs on that edge.
REQ-029 No output SHALL depend on an initial block; reset SHALL be the only initialisation.

Structure
REQ-030 The shared package counter_pkg SHALL hold the MODE_WRAP=0 and MODE_ONESHOT=1 constants and the direction constants DIR_UP=1 and DIR_DN=0.
REQ-031 The next-value and terminal detect logic SHALL be one combinational sub-module, cnt_next (inputs count, up_dn; outputs nxt, at_term), instantiated once.
REQ-032 The top level SHALL contain only the count, wrap and done registers, the priority mux and the load clamp.

Verification (WIDTH=4, MODULUS=10 unless noted)
REQ-033 The bench SHALL check: rst, then en=1, up_dn=0 for 12 cycles -> count 9,8,...,0,9,8; wrap=1 only the cycle after 0->9.
REQ-034 The bench SHALL check: up_dn=1 from 8 -> 9 (tc=1), 0 (wrap=1 the next cycle), 1.
REQ-035 The bench SHALL check: load=1, load_val=13, with en=1 -> count=9 and wrap=0; then load_val=4 -> count=4.
REQ-036 The bench SHALL check MODE=1, up_dn=0 from 2 -> 1, 0 with done=1; count stays 0 for 5 cycles with wrap=0; load 7 -> done=0, count=7.
REQ-037 The bench SHALL check: rst asserted together with load=1 and en=1 while count=5 -> count=9 (INIT), wrap=0, done=0.
REQ-038 The bench SHALL check WIDTH=4, MODULUS=16, up_dn=1 from 15 -> 0 and wrap=1, with no X and no overflow.
